// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches 16-bit words over a req/rdy
// handshake and presents one instruction at a time to decode.
module fetch_unit #(
   parameter int                  PC_WIDTH  = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter logic [15:0]         NOP_INSTR = 16'h0800
) (
   input  logic                clk,
   input  logic                rst,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_rdy,
   input  logic [15:0]         imem_data,
   output logic [15:0]         instr,
   output logic                instr_valid,
   output logic [PC_WIDTH-1:0] pc,
   output logic [PC_WIDTH-1:0] pc_plus2,
   input  logic                stall,
   input  logic                pc_sel,
   input  logic [PC_WIDTH-1:0] br_target,
   input  logic                halt,
   output logic                halted
);

   typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

   state_t              state, state_next;
   logic [PC_WIDTH-1:0] pc_q, pc_next;
   logic [15:0]         instr_q, instr_next;
   logic                valid_q, valid_next;
   logic                halted_q, halted_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state    <= state_next;
         pc_q     <= pc_next;
         instr_q  <= instr_next;
         valid_q  <= valid_next;
         halted_q <= halted_next;
      end
   end

   // Decode's redirect/halt inputs only matter on the cycle the held
   // instruction is actually consumed (HOLD with stall low).
   always_comb begin
      state_next  = state;
      pc_next     = pc_q;
      instr_next  = instr_q;
      valid_next  = valid_q;
      halted_next = halted_q;
      case (state)
         FETCH: begin
            if (imem_rdy) begin
               instr_next = imem_data;
               valid_next = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (!stall) begin
               valid_next = 1'b0;
               instr_next = NOP_INSTR;
               if (halt) begin
                  state_next  = HALTED;
                  halted_next = 1'b1;
               end else if (pc_sel) begin
                  pc_next    = {br_target[PC_WIDTH-1:1], 1'b0};
                  state_next = FETCH;
               end else begin
                  pc_next    = pc_plus2;
                  state_next = FETCH;
               end
            end
         end
         HALTED: begin
            state_next = HALTED;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   assign imem_req    = (state == FETCH) & ~rst;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign pc_plus2    = pc_q + PC_WIDTH'(2);
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the main fetch/stall/
// redirect/halt flow plus hand-written halted, wraparound and reset sequences.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic        instr_valid;
   logic [15:0] pc;
   logic [15:0] pc_plus2;
   logic        stall;
   logic        pc_sel;
   logic [15:0] br_target;
   logic        halt;
   logic        halted;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdy(imem_rdy), .imem_data(imem_data),
      .instr(instr), .instr_valid(instr_valid),
      .pc(pc), .pc_plus2(pc_plus2),
      .stall(stall), .pc_sel(pc_sel), .br_target(br_target),
      .halt(halt), .halted(halted)
   );

   // Instruction memory contents
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h0000: mem_word = 16'h4123;
         16'h0002: mem_word = 16'h0800;
         default:  mem_word = a ^ 16'hA5A5;
      endcase
   endfunction

   always_comb imem_data = mem_word(imem_addr);

   typedef struct {
      logic        rst, rdy, stall, pc_sel, halt;
      logic [15:0] br;
      logic        e_req;
      logic [15:0] e_addr;
      logic        e_valid;
      logic [15:0] e_instr;
      logic        e_halted;
   } vec_t;

   task automatic applyStimulus(input logic r, input logic rdy, input logic st,
                                input logic ps, input logic h, input logic [15:0] br);
      @(negedge clk);
      rst = r; imem_rdy = rdy; stall = st; pc_sel = ps; halt = h; br_target = br;
   endtask

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic e_req, input logic [15:0] e_addr,
                              input logic e_valid, input logic [15:0] e_instr,
                              input logic e_halted);
      logic [15:0] e_p2;
      e_p2 = e_addr + 16'd2;
      #1;
      cmp({tag, ".imem_req"},    {15'b0, imem_req},    {15'b0, e_req});
      cmp({tag, ".imem_addr"},   imem_addr,            e_addr);
      cmp({tag, ".pc"},          pc,                   e_addr);
      cmp({tag, ".pc_plus2"},    pc_plus2,             e_p2);
      cmp({tag, ".instr_valid"}, {15'b0, instr_valid}, {15'b0, e_valid});
      cmp({tag, ".instr"},       instr,                e_instr);
      cmp({tag, ".halted"},      {15'b0, halted},      {15'b0, e_halted});
   endtask

   vec_t vecs[15];

   initial begin
      rst = 1'b1; imem_rdy = 1'b0; stall = 1'b0; pc_sel = 1'b0; halt = 1'b0;
      br_target = 16'h0000;

      //          rst  rdy  stl  psel halt br        req  addr      vld  instr     hlt
      vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000,1'b0,16'h0800,1'b0};
      vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,1'b1,16'h4123,1'b0};
      vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,1'b0,16'h0800,1'b0};
      vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,1'b0,16'h0800,1'b0};
      vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,1'b0,16'h0800,1'b0};
      vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,1'b0,16'h0800,1'b0};
      vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,16'h0040, 1'b0,16'h0002,1'b1,16'h0800,1'b0};
      vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,16'h0040, 1'b0,16'h0002,1'b1,16'h0800,1'b0};
      vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,16'h0040, 1'b0,16'h0002,1'b1,16'h0800,1'b0};
      vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,16'h0040, 1'b0,16'h0002,1'b1,16'h0800,1'b0};
      vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,16'h0041, 1'b0,16'h0002,1'b1,16'h0800,1'b0};
      vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0040,1'b0,16'h0800,1'b0};
      vecs[12] = '{1'b0,1'b0,1'b1,1'b0,1'b1,16'h0000, 1'b0,16'h0040,1'b1,16'hA5E5,1'b0};
      vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b1,16'h0100, 1'b0,16'h0040,1'b1,16'hA5E5,1'b0};
      vecs[14] = '{1'b0,1'b1,1'b0,1'b1,1'b0,16'h0100, 1'b0,16'h0040,1'b0,16'h0800,1'b1};

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("reset", 1'b0, 16'h0000, 1'b0, 16'h0800, 1'b0);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].stall, vecs[i].pc_sel,
                       vecs[i].halt, vecs[i].br);
         checkOutput($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                     vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_halted);
      end

      // Halted ignores every input except reset
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, i[0], 1'b1, ~i[0], 16'h0200);
         checkOutput($sformatf("halted%0d", i), 1'b0, 16'h0040, 1'b0, 16'h0800, 1'b1);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("halt_rst", 1'b0, 16'h0040, 1'b0, 16'h0800, 1'b1);

      // Resume from reset, redirect to odd target, then wrap past 16'hFFFE
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("resume", 1'b1, 16'h0000, 1'b0, 16'h0800, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
      checkOutput("hold0", 1'b0, 16'h0000, 1'b1, 16'h4123, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("fetch_fffe", 1'b1, 16'hFFFE, 1'b0, 16'h0800, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("hold_fffe", 1'b0, 16'hFFFE, 1'b1, 16'h5A5B, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("wrap", 1'b1, 16'h0000, 1'b0, 16'h0800, 1'b0);

      // Reset during FETCH with a late rdy that must not be captured
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020);
      checkOutput("hold_w", 1'b0, 16'h0000, 1'b1, 16'h4123, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("fetch20", 1'b1, 16'h0020, 1'b0, 16'h0800, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("rst_fetch", 1'b0, 16'h0020, 1'b0, 16'h0800, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("after_rst_fetch", 1'b1, 16'h0000, 1'b0, 16'h0800, 1'b0);

      // Reset during HOLD wins over a redirect
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020);
      checkOutput("hold_b", 1'b0, 16'h0000, 1'b1, 16'h4123, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("fetch20b", 1'b1, 16'h0020, 1'b0, 16'h0800, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0080);
      checkOutput("rst_hold", 1'b0, 16'h0020, 1'b1, 16'hA585, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      checkOutput("after_rst_hold", 1'b1, 16'h0000, 1'b0, 16'h0800, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
